triangle_sides_sched: RTL and testbench

Round-robin scheduler that shares one combinational `get_triangle_sides` unit among `N_REQ` requesters in the vga_cube pipeline, for example per-edge projection engines. Each requester presents an angle/hypotenuse pair on a valid/ready handshake. The scheduler grants one requester, registers the operands, and holds the tagged a/b/c result on a single response port until it is consumed. It also range-checks operands so that out-of-domain values never reach the trig unit.

---
 rtl/vga_cube_pkg.sv | 19 +
 rtl/get_triangle_sides.sv | 42 ++++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/triangle_sides_sched.sv | 140 ++++++++++++++
 tb/tb_triangle_sides_sched.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_cube_pkg.sv
// Shared vga_cube types: scheduler state encoding, trig operand bundle and
// the default legal angle bound.
package vga_cube_pkg;

  localparam int ANGLE_MAX_DEFAULT = 90;
  localparam int unsigned TRIG_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } sched_state_t;

  typedef struct packed {
    logic signed [TRIG_WIDTH-1:0] angle;
    logic signed [TRIG_WIDTH-1:0] hyp;
  } trig_req_t;

endpackage

// File: rtl/get_triangle_sides.sv
// Combinational right-triangle sides: a = hyp*sin(angle), b = hyp*cos(angle), c = hyp,
// with sine from Bhaskara I's rational approximation over whole degrees 0..180.
module get_triangle_sides #(
  parameter int unsigned WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] angle,
  input  logic signed [WIDTH-1:0] hyp,
  output logic signed [WIDTH-1:0] a,
  output logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] c
);

  // 18 guard bits hold hyp * 4*x*(180-x) (at most 32400 < 2^15) without overflow.
  localparam int unsigned PW = WIDTH + 18;
  localparam logic signed [PW-1:0] Deg90  = PW'(90);
  localparam logic signed [PW-1:0] Deg180 = PW'(180);
  localparam logic signed [PW-1:0] Four   = PW'(4);
  localparam logic signed [PW-1:0] Denom  = PW'(40500);

  logic signed [PW-1:0] w_ang_a;
  logic signed [PW-1:0] w_ang_b;
  logic signed [PW-1:0] w_hyp;
  logic signed [PW-1:0] w_pa;
  logic signed [PW-1:0] w_pb;
  logic signed [PW-1:0] w_qa;
  logic signed [PW-1:0] w_qb;

  assign w_ang_a = {{18{angle[WIDTH-1]}}, angle};
  assign w_ang_b = Deg90 - w_ang_a;
  assign w_hyp   = {{18{hyp[WIDTH-1]}}, hyp};

  assign w_pa = w_ang_a * (Deg180 - w_ang_a);
  assign w_pb = w_ang_b * (Deg180 - w_ang_b);

  assign w_qa = (w_hyp * (Four * w_pa)) / (Denom - w_pa);
  assign w_qb = (w_hyp * (Four * w_pb)) / (Denom - w_pb);

  assign a = w_qa[WIDTH-1:0];
  assign b = w_qb[WIDTH-1:0];
  assign c = hyp;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the requester after the last winner and
// moves its pointer only when the caller reports the grant was taken.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grant_idx
);

  localparam logic [IdxW:0] NumReq = (IdxW+1)'(N);

  logic [IdxW-1:0] r_ptr;
  logic [IdxW:0]   w_sum;
  logic [IdxW-1:0] w_cand;
  logic            w_found;

  // Wrap ptr+i into 0..N-1 without a modulo so any N in 2..16 works.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_sum  = {1'b0, r_ptr} + (IdxW+1)'(i);
      w_cand = (w_sum >= NumReq) ? IdxW'(w_sum - NumReq) : IdxW'(w_sum);
      if (!w_found && req[w_cand]) begin
        w_found       = 1'b1;
        grant[w_cand] = 1'b1;
        grant_idx     = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= IdxW'(N - 1);
    end else if (advance && w_found) begin
      r_ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/triangle_sides_sched.sv
// Shares one get_triangle_sides unit among N_REQ requesters: grant, register
// operands, compute for one cycle, then hold the tagged result until consumed.
module triangle_sides_sched
  import vga_cube_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int          ANGLE_MAX = ANGLE_MAX_DEFAULT,
  localparam int unsigned IdW      = $clog2(N_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_valid,
  output logic [N_REQ-1:0]                  req_ready,
  input  logic [N_REQ-1:0][WIDTH-1:0]       req_angle,
  input  logic [N_REQ-1:0][WIDTH-1:0]       req_hyp,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [IdW-1:0]                    resp_id,
  output logic signed [WIDTH-1:0]           resp_a,
  output logic signed [WIDTH-1:0]           resp_b,
  output logic signed [WIDTH-1:0]           resp_c,
  output logic                              resp_err,
  output logic                              busy
);

  localparam logic signed [WIDTH-1:0] AngleMaxS = WIDTH'(ANGLE_MAX);

  sched_state_t            r_state;
  logic signed [WIDTH-1:0] r_angle;
  logic signed [WIDTH-1:0] r_hyp;
  logic [IdW-1:0]          r_id;
  logic                    r_resp_valid;
  logic [IdW-1:0]          r_resp_id;
  logic signed [WIDTH-1:0] r_a;
  logic signed [WIDTH-1:0] r_b;
  logic signed [WIDTH-1:0] r_c;
  logic                    r_err;

  logic [N_REQ-1:0]        w_grant;
  logic [IdW-1:0]          w_grant_idx;
  logic                    w_accept;
  logic                    w_take;
  logic                    w_err;
  logic signed [WIDTH-1:0] w_trig_angle;
  logic signed [WIDTH-1:0] w_trig_hyp;
  logic signed [WIDTH-1:0] w_a;
  logic signed [WIDTH-1:0] w_b;
  logic signed [WIDTH-1:0] w_c;

  // A grant is only offered when the operand slot is free this cycle.
  assign w_accept  = rst && ((r_state == IDLE) || ((r_state == RESP) && resp_ready));
  assign w_take    = w_accept && (|req_valid);
  assign req_ready = w_accept ? w_grant : '0;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (w_accept),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_err = r_angle[WIDTH-1] || (r_angle > AngleMaxS) || r_hyp[WIDTH-1];

  // Out-of-domain operands are replaced by zeros before they reach the trig unit.
  assign w_trig_angle = w_err ? '0 : r_angle;
  assign w_trig_hyp   = w_err ? '0 : r_hyp;

  get_triangle_sides #(
    .WIDTH (WIDTH)
  ) u_trig (
    .angle (w_trig_angle),
    .hyp   (w_trig_hyp),
    .a     (w_a),
    .b     (w_b),
    .c     (w_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_angle      <= '0;
      r_hyp        <= '0;
      r_id         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_err        <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_take) begin
            r_angle <= req_angle[w_grant_idx];
            r_hyp   <= req_hyp[w_grant_idx];
            r_id    <= w_grant_idx;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_resp_valid <= 1'b1;
          r_resp_id    <= r_id;
          r_a          <= w_err ? '0 : w_a;
          r_b          <= w_err ? '0 : w_b;
          r_c          <= w_err ? '0 : w_c;
          r_err        <= w_err;
          r_state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            if (w_take) begin
              r_angle <= req_angle[w_grant_idx];
              r_hyp   <= req_hyp[w_grant_idx];
              r_id    <= w_grant_idx;
              r_state <= CALC;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_a     = r_a;
  assign resp_b     = r_b;
  assign resp_c     = r_c;
  assign resp_err   = r_err;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_triangle_sides_sched.sv
// Randomised bench for triangle_sides_sched against a cycle-level reference of
// the request/response protocol and an arithmetic model of the triangle sides.
module tb_triangle_sides_sched;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int AMAX = 90;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_ready;
  logic [N-1:0][W-1:0]    req_angle;
  logic [N-1:0][W-1:0]    req_hyp;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [1:0]             resp_id;
  logic signed [W-1:0]    resp_a;
  logic signed [W-1:0]    resp_b;
  logic signed [W-1:0]    resp_c;
  logic                   resp_err;
  logic                   busy;

  triangle_sides_sched #(
    .N_REQ     (N),
    .WIDTH     (W),
    .ANGLE_MAX (AMAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_angle  (req_angle),
    .req_hyp    (req_hyp),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_a     (resp_a),
    .resp_b     (resp_b),
    .resp_c     (resp_c),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // hyp * sin(deg) using Bhaskara I's formula, the trig unit's documented behaviour.
  function automatic longint hyp_sin(input longint h, input longint deg);
    longint p;
    p = deg * (180 - deg);
    return (h * 4 * p) / (40500 - p);
  endfunction

  function automatic void ref_sides(input longint ang, input longint hyp,
                                    output longint a, output longint b,
                                    output longint c, output bit err);
    err = (ang < 0) || (ang > AMAX) || (hyp < 0);
    a = 0;
    b = 0;
    c = 0;
    if (!err) begin
      a = hyp_sin(hyp, ang);
      b = hyp_sin(hyp, 90 - ang);
      c = hyp;
    end
  endfunction

  // Reference: an operand is either being computed, waiting as a response, or absent.
  bit     m_calc = 1'b0;
  bit     m_resp = 1'b0;
  int     m_ptr  = N - 1;
  longint m_ang, m_hyp;
  int     m_id;
  longint e_a, e_b, e_c;
  bit     e_err;
  int     e_id;

  // Inputs are driven 1 time unit after posedge; outputs are sampled mid-cycle.
  task automatic cycle();
    int           win;
    bit           acc;
    logic [N-1:0] exp_rdy;
    #3;
    win = -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (win < 0 && req_valid[j]) win = j;
    end
    acc = rst && !m_calc && (!m_resp || resp_ready) && (win >= 0);
    exp_rdy = '0;
    if (acc) exp_rdy[win] = 1'b1;
    check_eq("req_ready", longint'(req_ready), longint'(exp_rdy));
    check_eq("resp_valid", longint'(resp_valid), longint'(m_resp));
    check_eq("busy", longint'(busy), longint'(m_calc || m_resp));
    if (m_resp) begin
      check_eq("resp_id", longint'(resp_id), longint'(e_id));
      check_eq("resp_a", resp_a, e_a);
      check_eq("resp_b", resp_b, e_b);
      check_eq("resp_c", resp_c, e_c);
      check_eq("resp_err", longint'(resp_err), longint'(e_err));
    end
    @(posedge clk);
    if (!rst) begin
      m_calc = 1'b0;
      m_resp = 1'b0;
      m_ptr  = N - 1;
    end else begin
      if (m_calc) begin
        m_calc = 1'b0;
        m_resp = 1'b1;
        ref_sides(m_ang, m_hyp, e_a, e_b, e_c, e_err);
        e_id = m_id;
      end else if (m_resp && resp_ready) begin
        m_resp = 1'b0;
      end
      if (acc) begin
        m_calc = 1'b1;
        m_ang  = longint'($signed(req_angle[win]));
        m_hyp  = longint'($signed(req_hyp[win]));
        m_id   = win;
        m_ptr  = win;
      end
    end
    #1;
  endtask

  task automatic single_req(input int idx, input int ang, input int hyp);
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    req_angle[idx] = ang;
    req_hyp[idx]   = hyp;
    cycle();
    req_valid = '0;
    repeat (3) cycle();
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    req_angle  = '0;
    req_hyp    = '0;
    @(posedge clk);
    #1;

    // Reset values, and no grant while reset is held even with requests pending.
    cycle();
    req_valid  = '1;
    resp_ready = 1'b1;
    cycle();
    check_eq("rst_resp_id", longint'(resp_id), 0);
    check_eq("rst_resp_a", resp_a, 0);
    check_eq("rst_resp_b", resp_b, 0);
    check_eq("rst_resp_c", resp_c, 0);
    check_eq("rst_resp_err", longint'(resp_err), 0);
    rst       = 1'b1;
    req_valid = '0;
    cycle();

    // Single request: 45 deg, hyp 10 -> a = b = 7, c = 10 two edges after the grant.
    req_valid    = 4'b0001;
    req_angle[0] = 45;
    req_hyp[0]   = 10;
    cycle();
    req_valid = '0;
    cycle();
    check_eq("single_a", resp_a, 7);
    check_eq("single_b", resp_b, 7);
    check_eq("single_c", resp_c, 10);
    repeat (2) cycle();

    // Fairness from a fresh reset: grant order 0,1,2,3,0...
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_angle[i] = 30;
      req_hyp[i]   = 20;
    end
    req_valid  = '1;
    resp_ready = 1'b1;
    repeat (10) cycle();
    req_valid = '0;
    repeat (3) cycle();

    // Backpressure: response held while req2 waits, then back-to-back grant.
    req_valid    = 4'b0001;
    req_angle[0] = 60;
    req_hyp[0]   = 100;
    resp_ready   = 1'b0;
    cycle();
    req_valid    = 4'b0100;
    req_angle[2] = 10;
    req_hyp[2]   = 55;
    repeat (7) cycle();
    resp_ready = 1'b1;
    cycle();
    req_valid = '0;
    repeat (3) cycle();

    // Domain edges.
    single_req(1, 91, 30);
    single_req(1, -1, 30);
    single_req(1, 45, -5);
    single_req(1, 90, 30);
    single_req(1, 0, 30);

    // Reset while an operand is in CALC; it is lost and the pointer restarts.
    req_valid    = 4'b0010;
    req_angle[1] = 20;
    req_hyp[1]   = 40;
    cycle();
    req_valid = '0;
    rst       = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    single_req(3, 75, 123);

    // Random traffic, sporadic resets and backpressure.
    for (int n = 0; n < 3000; n++) begin
      req_valid  = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req_valid = '0;
      resp_ready = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 9))
          0:       req_angle[i] = -1;
          1:       req_angle[i] = 91;
          2:       req_angle[i] = 90;
          3:       req_angle[i] = 0;
          4:       req_angle[i] = $urandom;
          default: req_angle[i] = $urandom_range(0, 90);
        endcase
        case ($urandom_range(0, 7))
          0:       req_hyp[i] = -int'($urandom_range(1, 100));
          1:       req_hyp[i] = 0;
          2:       req_hyp[i] = $urandom_range(0, 32'h7fff_ffff);
          default: req_hyp[i] = $urandom_range(0, 5000);
        endcase
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
